dist_bin2bcd: RTL
=================

// Module: dist_bin2bcd
// PURPOSE
//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble) between the
//   ultrasonic ranging stage and the 7-segment display driver.
//   Takes each new binary distance word and converts it over IN_W cycles.
//   Presents a registered, saturated DIGITS-digit BCD value with a one-cycle valid
//   strobe, so the display stage never divides or takes modulo.
// PARAMETERS
//   IN_W    33  width of binary distance input (matches ranging stage output)
//   DIGITS  4   number of BCD digits produced (one per HEX display)
//   CNT_W   6   width of bit counter; must satisfy 2**CNT_W > IN_W
// PORTS
//   clk        in   1          system clock (50 MHz domain of ranging stage)
//   rst        in   1          synchronous, active-high reset
//   in_valid   in   1          new distance word present on bin_in
//   bin_in     in   IN_W       unsigned binary distance (cm)
//   in_ready   out  1          converter idle, accepts a word this cycle
//   out_valid  out  1          one-cycle strobe: bcd_out/overflow updated
//   bcd_out    out  4*DIGITS   BCD result, digit 0 = bits [3:0] (least significant)
//   overflow   out  1          bin_in exceeded 10**DIGITS-1; bcd_out saturated
//   blank      out  DIGITS     leading-zero mask, 1 = digit blank (DIST_BLANK_EN only)
// BEHAVIOUR
//   - Single clock clk; rst synchronous active-high, sampled on rising edge only.
//   - Reset: state=IDLE, in_ready=1, out_valid=0, bcd_out=0, overflow=0, blank=0.
//   - FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   - IDLE: in_ready=1. On in_valid=1: load shift reg <= bin_in, clear scratch
//     BCD, cnt <= IN_W, latch ovf <= (bin_in > 10**DIGITS-1); go to SHIFT.
//   - SHIFT: in_ready=0. Each cycle, add 3 to every scratch digit >= 5, then shift
//     {bcd,shift} left by 1 and decrement cnt. When cnt reaches 1 (last shift done
//     this cycle) go to DONE. Exactly IN_W SHIFT cycles per conversion.
//   - DONE: register bcd_out (all digits 9 if ovf, else scratch), overflow <= ovf,
//     out_valid=1 for this cycle only, then go to IDLE.
//   - Latency: word accepted at edge T -> out_valid high in cycle T+IN_W+1 (34 for
//     defaults). Throughput: one word per IN_W+2 cycles.
//   - Scratch BCD is DIGITS digits wide; bits shifted out the top are discarded.
//     Overflow is decided from the load-time compare, never from scratch content.
//   - in_valid while in_ready=0 is ignored, not queued; upstream re-presents or the
//     next sample is taken.
//   - bcd_out, overflow and blank hold their last values between out_valid strobes.
//   - rst mid-conversion: return to IDLE next edge, outputs cleared, no out_valid.
//   - bin_in=0: result all-zero digits, overflow=0, normal latency (no shortcut).
// CONFIGURATION
//   DIST_BLANK_EN defined: in DONE, blank[i]=1 for every digit above the
//     highest non-zero digit; digit 0 never blanked. blank=0 when overflow=1.
//     Updated with bcd_out.
//   DIST_BLANK_EN undefined: blank port still present, tied to 0; no extra logic.
// TESTING
//   - bin_in=0, in_valid 1 cycle -> out_valid at +34 cycles, bcd_out=16'h0000, overflow=0.
//   - bin_in=1234 -> bcd_out=16'h1234, overflow=0, out_valid high exactly 1 cycle.
//   - bin_in=9999 -> 16'h9999, overflow=0; bin_in=10000 and 2**33-1 -> 16'h9999, overflow=1.
//   - bin_in=57 accepted, then in_valid with bin_in=88 at +5 cycles -> in_ready=0, ignored;
//     result 16'h0057, single out_valid.
//   - bin_in=4321, rst at +10 cycles -> no out_valid, bcd_out=0, in_ready=1 next cycle;
//     next bin_in=7 -> 16'h0007.
//   - DIST_BLANK_EN: bin_in=42 -> bcd_out=16'h0042, blank=4'b1100; bin_in=0 -> blank=4'b1110;
//     bin_in=12000 -> blank=4'b0000.

Source files
------------

// File: rtl/dist_bin2bcd.sv
// dist_bin2bcd: sequential binary-to-BCD converter (shift-add-3 / double-dabble).
// Converts one unsigned binary distance word over IN_W shift cycles. The result is
// registered and saturated to all nines when the input exceeds 10**DIGITS-1.
// Optional feature macro: DIST_BLANK_EN (leading-zero blanking mask on 'blank').
module dist_bin2bcd #(
   parameter int IN_W   = 33,
   parameter int DIGITS = 4,
   parameter int CNT_W  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [IN_W-1:0]       bin_in,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int BCD_W = 4 * DIGITS;
   localparam logic [IN_W-1:0] MAX_VAL = IN_W'(10**DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
   function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = v[4*i +: 4] + 4'd3;
         end else begin
            r[4*i +: 4] = v[4*i +: 4];
         end
      end
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic [IN_W-1:0]        shift_q, shift_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   ovf_q, ovf_d;
   logic                   out_valid_q, out_valid_d;
   logic [BCD_W-1:0]       bcd_out_q, bcd_out_d;
   logic                   overflow_q, overflow_d;
   logic [BCD_W+IN_W-1:0]  cat_s;

`ifdef DIST_BLANK_EN
   logic [DIGITS-1:0]      blank_q, blank_d;

   // Mark every digit above the highest non-zero digit; digit 0 always shown.
   function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] v);
      logic [DIGITS-1:0] m;
      logic              nz;
      m  = {DIGITS{1'b0}};
      nz = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         nz   = nz | (v[4*i +: 4] != 4'd0);
         m[i] = ~nz;
      end
      m[0] = 1'b0;
      return m;
   endfunction
`endif

   // Next-state, datapath and output-register load logic for the conversion FSM.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bcd_d       = bcd_q;
      cnt_d       = cnt_q;
      ovf_d       = ovf_q;
      out_valid_d = 1'b0;
      bcd_out_d   = bcd_out_q;
      overflow_d  = overflow_q;
      cat_s       = {bcd_q, shift_q};
`ifdef DIST_BLANK_EN
      blank_d     = blank_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_d = bin_in;
               bcd_d   = {BCD_W{1'b0}};
               cnt_d   = CNT_W'(IN_W);
               ovf_d   = (bin_in > MAX_VAL);
               state_d = S_SHIFT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            // Bits leaving the top of the scratch BCD are simply dropped.
            cat_s   = {add3_digits(bcd_q), shift_q} << 1;
            bcd_d   = cat_s[BCD_W+IN_W-1 -: BCD_W];
            shift_d = cat_s[IN_W-1:0];
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SHIFT;
            end
         end
         S_DONE: begin
            if (ovf_q) begin
               bcd_out_d = {DIGITS{4'h9}};
            end else begin
               bcd_out_d = bcd_q;
            end
            overflow_d  = ovf_q;
            out_valid_d = 1'b1;
`ifdef DIST_BLANK_EN
            if (ovf_q) begin
               blank_d = {DIGITS{1'b0}};
            end else begin
               blank_d = blank_mask(bcd_q);
            end
`endif
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= {IN_W{1'b0}};
         bcd_q       <= {BCD_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         bcd_out_q   <= {BCD_W{1'b0}};
         overflow_q  <= 1'b0;
`ifdef DIST_BLANK_EN
         blank_q     <= {DIGITS{1'b0}};
`endif
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bcd_q       <= bcd_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
         bcd_out_q   <= bcd_out_d;
         overflow_q  <= overflow_d;
`ifdef DIST_BLANK_EN
         blank_q     <= blank_d;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign bcd_out   = bcd_out_q;
   assign overflow  = overflow_q;
`ifdef DIST_BLANK_EN
   assign blank     = blank_q;
`else
   assign blank     = {DIGITS{1'b0}};
`endif

endmodule
